nibble_serial_adder: RTL and testbench
======================================

Name: nibble_serial_adder

Overview:
- Multi-word adder that sums WIDTH-bit operands 4 bits per clock through one 4-bit carry-lookahead slice.
- Latches operands on a valid/ready handshake and feeds successive nibbles, LSB first, into the slice.
- Carries the slice carry-out into the next nibble through a carry register.
- Presents the full sum and final carry on a valid/ready output handshake.
- Serves as the area-lean wide adder feeding downstream accumulators.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4 and at least 4; elaboration error otherwise.
- NIB (localparam), WIDTH/4, number of nibble steps.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to nibble 0.
- out_valid  output  1  sum/cout valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result A+B+cin mod 2^WIDTH.
- cout  output  1  carry out of MSB.

Behaviour:
- Reset: asynchronous, active-low; clk and rst_n are the only clock and reset.
- State on reset: FSM=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, nibble index=0, carry reg=0, operand regs=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a, b; carry reg<=cin; index<=0; go to RUN.
  - Inputs are ignored otherwise.
- RUN:
  - in_ready=0.
  - Each cycle, the slice adds nibble[index] of A, B and the carry reg.
  - The slice sum is written to sum[4*index+:4]; carry reg<=slice carry-out; index<=index+1.
  - When index==NIB-1, cout<=slice carry-out and the FSM goes to DONE.
- DONE:
  - out_valid=1; sum and cout are stable.
  - On out_ready: out_valid drops the next cycle and the FSM goes to IDLE.
  - Without out_ready, results hold indefinitely.
  - in_ready=0, so no new operands are accepted in DONE.
- Latency: out_valid rises NIB cycles after the accepting edge (4 for WIDTH=16).
- Throughput: at most one operation per NIB+2 cycles.
- Operand changes after acceptance have no effect.
- sum bits not yet written in RUN retain the previous result; they are not observable because out_valid=0.
- Reset mid-operation: the operation is discarded and the block is in IDLE with all outputs at their reset values.
- The index counter is $clog2(NIB) bits wide, minimum 1 bit; it never wraps past NIB-1.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), latched with the operands on acceptance.
  - sub=1: B is inverted at latch, carry reg<=1, cin is ignored, and the result is A-B mod 2^WIDTH.
  - sub=1: cout=1 means no borrow (A>=B unsigned).
  - sub=0: identical to the undefined build.
- Undefined: no sub port; addition only.

Decomposition:
- Package nibble_serial_adder_pkg:
  - FSM state enum (IDLE, RUN, DONE).
  - NIBBLE_W=4 constant.
  - Helper function computing index width from WIDTH.
- Sub-module cla4_slice: purely combinational 4-bit carry-lookahead adder.
  - Ports: a[3:0], b[3:0], ci, s[3:0], co.
  - Logic: G=a&b, P=a^b, c1=G0|P0&ci, ..., s=P^{c3,c2,c1,ci}.
  - Instantiated once.

Test Plan (WIDTH=16):
- Carry ripple:
  - Stimulus: a=0xFFFF, b=0x0001, cin=0.
  - Response: out_valid 4 cycles after accept; sum=0x0000, cout=1.
- Carry-in path:
  - Stimulus: a=0x1234, b=0x4321, cin=1.
  - Response: sum=0x5556, cout=0; in_ready low from accept until the return to IDLE.
- Backpressure:
  - Stimulus: a=0x8000, b=0x8000, cin=0; out_ready low for 5 cycles after out_valid.
  - Response: sum=0x0000 and cout=1 held stable; out_valid drops the cycle after out_ready=1.
- Reset mid-run:
  - Stimulus: accept a=0x0F0F, b=0x0101; assert rst_n=0 during RUN index 2.
  - Response: outputs immediately 0, in_ready=1.
  - Follow-up: next op a=0x0002, b=0x0003 gives sum=0x0005.
- Back-to-back with late input change:
  - Stimulus: in_valid held high with two operand sets (0x00FF+0x0001, then 0x7FFF+0x0001); alter a during RUN.
  - Response: results 0x0100/0 then 0x8000/0; second accept occurs only after the first result handshake; the alteration is ignored.
- Subtract (NIBBLE_SERIAL_ADDER_SUB_EN):
  - Stimulus: sub=1, a=0x0005, b=0x0007 -> sum=0xFFFE, cout=0.
  - Stimulus: sub=1, a=0x0007, b=0x0005 -> sum=0x0002, cout=1.

Source files
------------

// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Index counter width for a WIDTH-bit operand; never narrower than 1 bit.
  function automatic int idx_w(input int width);
    int n;
    n = width / NIBBLE_W;
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/nibble_serial_adder_cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [3:0] g, p;
  logic       c1, c2, c3;

  assign g  = a & b;
  assign p  = a ^ b;
  assign c1 = g[0] | (p[0] & ci);
  assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
  assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
  assign co = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
            | (p[3] & p[2] & p[1] & p[0] & ci);
  assign s  = p ^ {c3, c2, c1, ci};

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder that walks operands one nibble per clock through a single CLA slice.
// Optional subtract mode (adds port sub) when NIBBLE_SERIAL_ADDER_SUB_EN is defined.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB = WIDTH / NIBBLE_W;
  localparam int IW  = idx_w(WIDTH);
  localparam logic [IW-1:0] LAST = IW'(NIB - 1);

  generate
    if (WIDTH < NIBBLE_W || (WIDTH % NIBBLE_W) != 0) begin : g_bad_width
      $error("nibble_serial_adder: WIDTH must be a positive multiple of 4");
    end
  endgenerate

  state_t                          state;
  logic [NIB-1:0][NIBBLE_W-1:0]    a_q, b_q, sum_q;
  logic [IW-1:0]                   idx;
  logic                            carry;
  logic [NIBBLE_W-1:0]             s_nib;
  logic                            co_nib;
  logic [WIDTH-1:0]                b_in;
  logic                            c_in;

  // Subtraction is A + ~B + 1, so inversion and the forced carry happen at latch time.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  cla4_slice u_slice (
    .a  (a_q[idx]),
    .b  (b_q[idx]),
    .ci (carry),
    .s  (s_nib),
    .co (co_nib)
  );

  assign sum = sum_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum_q     <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      carry     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b_in;
            carry    <= c_in;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          sum_q[idx] <= s_nib;
          carry      <= co_nib;
          if (idx == LAST) begin
            cout      <= co_nib;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Scoreboard bench for nibble_serial_adder (WIDTH=16); directed vectors.
module tb_nibble_serial_adder;

  localparam int W = 16;

  logic         clk, rst_n, in_valid, in_ready, cin, out_valid, out_ready, cout;
  logic [W-1:0] a, b, sum;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  nibble_serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int hs    = 0;
  logic [W:0] exp_q[$];
  int         acc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: samples between edges, checks latency, holds and pops on handshake.
  initial begin
    logic prev_ov;
    logic [W:0] e;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        if (in_valid && in_ready) acc_q.push_back(cyc + 1);
        if (out_valid) begin
          chk("in_ready_low_in_done", {31'd0, in_ready}, 32'd0);
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 32'd1, 32'd0);
          end else begin
            e = exp_q[0];
            if (!prev_ov) begin
              if (acc_q.size() == 0) chk("latency_no_accept", 32'd1, 32'd0);
              else chk("latency", 32'(cyc - acc_q.pop_front()), 32'd4);
            end
            chk("sum", {16'd0, sum}, {16'd0, e[W-1:0]});
            chk("cout", {31'd0, cout}, {31'd0, e[W]});
            if (out_ready) begin
              void'(exp_q.pop_front());
              hs++;
            end
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic set_in(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                        input logic ts);
    a = ta; b = tb_; cin = tc;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) chk("sub_not_built", 32'd1, 32'd0);
`endif
  endtask

  // Issue one op; returns at the negedge right after the accepting edge.
  task automatic op(input logic [W-1:0] ta, input logic [W-1:0] tb_, input logic tc,
                    input logic ts, input logic [W-1:0] es, input logic ec);
    int n;
    exp_q.push_back({ec, es});
    @(negedge clk);
    set_in(ta, tb_, tc, ts);
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) chk("accept_timeout", 32'd1, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'hDEAD; b = 16'hBEEF; cin = ~tc;
    chk("in_ready_after_accept", {31'd0, in_ready}, 32'd0);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(in_ready && exp_q.size() == 0) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, h0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_in('0, '0, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {16'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    rst_n = 1'b1;

    // carry ripple across every nibble
    op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    wait_idle();
    // carry-in path
    op(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);
    chk("in_ready_run2", {31'd0, in_ready}, 32'd0);
    wait_idle();

    // backpressure: hold result for 5 cycles
    out_ready = 1'b0;
    op(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1);
    n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("bp_valid_timeout", 32'd1, 32'd0);
    repeat (5) @(negedge clk);
    chk("bp_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop", {31'd0, out_valid}, 32'd0);
    wait_idle();

    // reset during RUN index 2
    op(16'h0F0F, 16'h0101, 1'b0, 1'b0, 16'h1010, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    acc_q.delete();
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_sum", {16'd0, sum}, 32'd0);
    chk("midrst_cout", {31'd0, cout}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    op(16'h0002, 16'h0003, 1'b0, 1'b0, 16'h0005, 1'b0);
    wait_idle();

    // back-to-back with in_valid held and operands altered mid-run
    exp_q.push_back({1'b0, 16'h0100});
    exp_q.push_back({1'b0, 16'h8000});
    @(negedge clk);
    set_in(16'h00FF, 16'h0001, 1'b0, 1'b0);
    in_valid = 1'b1;
    @(negedge clk);
    a = 16'h7FFF;
    h0 = hs;
    n = 0;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("b2b_order", 32'(hs - h0), 32'd1);
    @(negedge clk);
    a = 16'hAAAA;
    @(negedge clk);
    in_valid = 1'b0;
    wait_idle();

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    wait_idle();
    op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1);
    wait_idle();
    op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
    wait_idle();
`endif

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    chk("handshakes", 32'(hs), 32'd6
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
        + 32'd3
`endif
    );
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
